// File: rtl/aes_pkg.sv
// Shared constants, FIFO payload type and credit helper for the AES ciphertext collector.
// The payload carries a tag field only when AES_COLLECT_TAG_EN is defined.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W  = 128;
  localparam int unsigned AES_PIPE_LAT = 11;
  localparam int unsigned AES_TAG_W    = 4;
  localparam int unsigned AES_FIFO_MAX = 16;
  localparam int unsigned AES_CNT_W    = $clog2(AES_FIFO_MAX + 1);
  localparam int unsigned AES_CRED_W   = 8;

  typedef struct packed {
    logic [AES_BLOCK_W-1:0] ct;
`ifdef AES_COLLECT_TAG_EN
    logic [AES_TAG_W-1:0]   tag;
`endif
  } ct_entry_t;

  // True while outstanding blocks plus buffered entries leave room for one more.
  function automatic logic credit_ok(input logic [AES_CRED_W-1:0] inflight,
                                     input logic [AES_CRED_W-1:0] cnt,
                                     input logic [AES_CRED_W-1:0] depth);
    return ({1'b0, inflight} + {1'b0, cnt}) < {1'b0, depth};
  endfunction

endpackage

// File: rtl/aes_ct_fifo.sv
// First-word-fall-through ciphertext FIFO with modulo-DEPTH pointers and a sticky overflow flag.
// Also exposes its next-cycle occupancy so the credit logic can stay fully registered.
module aes_ct_fifo
  import aes_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en_i,
  input  ct_entry_t            wr_data_i,
  input  logic                 rd_en_i,
  output ct_entry_t            rd_data_o,
  output logic                 valid_o,
  output logic [AES_CNT_W-1:0] cnt_d_o,
  output logic                 ovf_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ct_entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AES_CNT_W-1:0] cnt_q, cnt_d;
  logic                 valid_q;
  logic                 ovf_q, ovf_d;
  logic                 full, push, pop;

  // A write into a full FIFO only lands if the head leaves in the same cycle.
  always_comb begin
    full     = (cnt_q == AES_CNT_W'(DEPTH));
    pop      = rd_en_i && valid_q;
    push     = wr_en_i && (!full || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    cnt_d    = cnt_q + AES_CNT_W'(push) - AES_CNT_W'(pop);
    ovf_d    = ovf_q || (wr_en_i && !push);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      valid_q  <= (cnt_d != '0);
      ovf_q    <= ovf_d;
    end
  end

  // Storage is cleared on reset so no stale ciphertext can reappear at the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign valid_o   = valid_q;
  assign cnt_d_o   = cnt_d;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/aes_ct_collect.sv
// Collects aes_top ciphertext into a credit-controlled FIFO using a valid delay line.
// Define AES_COLLECT_TAG_EN to add in_tag/ct_tag, carried alongside each block.
module aes_ct_collect
  import aes_pkg::*;
#(
  parameter int unsigned LAT   = AES_PIPE_LAT,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] cryptokey,
`ifdef AES_COLLECT_TAG_EN
  input  logic [AES_TAG_W-1:0]   in_tag,
  output logic [AES_TAG_W-1:0]   ct_tag,
`endif
  output logic [AES_BLOCK_W-1:0] ct_data,
  output logic                   ct_valid,
  input  logic                   ct_ready,
  output logic                   ovf_err
);

  localparam int unsigned INF_W = $clog2(LAT + 1);

  logic [LAT-1:0]       dl_q, dl_d;
  logic [INF_W-1:0]     inflight_q, inflight_d;
  logic                 in_ready_q, in_ready_d;
  logic                 issue, tail;
  logic [AES_CNT_W-1:0] fifo_cnt_d;
  ct_entry_t            wr_data, rd_data;

  // Issue tracking and credit: in_ready is registered from next-state occupancy.
  always_comb begin
    issue      = in_valid && in_ready_q;
    tail       = dl_q[LAT-1];
    dl_d       = {dl_q[LAT-2:0], issue};
    inflight_d = inflight_q;
    case ({issue, tail})
      2'b10:   inflight_d = inflight_q + INF_W'(1);
      2'b01:   inflight_d = inflight_q - INF_W'(1);
      default: inflight_d = inflight_q;
    endcase
    in_ready_d = credit_ok(AES_CRED_W'(inflight_d), AES_CRED_W'(fifo_cnt_d), AES_CRED_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dl_q       <= '0;
      inflight_q <= '0;
      in_ready_q <= 1'b0;
    end else begin
      dl_q       <= dl_d;
      inflight_q <= inflight_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef AES_COLLECT_TAG_EN
  logic [AES_TAG_W-1:0] tag_q [LAT];

  // Tag shift line runs in lockstep with the valid delay line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(LAT); i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= in_tag;
      for (int i = 1; i < int'(LAT); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign ct_tag = rd_data.tag;
`endif

  always_comb begin
    wr_data    = '0;
    wr_data.ct = cryptokey;
`ifdef AES_COLLECT_TAG_EN
    wr_data.tag = tag_q[LAT-1];
`endif
  end

  aes_ct_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .wr_en_i   (tail),
    .wr_data_i (wr_data),
    .rd_en_i   (ct_ready),
    .rd_data_o (rd_data),
    .valid_o   (ct_valid),
    .cnt_d_o   (fifo_cnt_d),
    .ovf_o     (ovf_err)
  );

  assign in_ready = in_ready_q;
  assign ct_data  = rd_data.ct;

endmodule

// File: tb/tb_aes_ct_collect.sv
// Directed bench for aes_ct_collect: a stand-in aes_top pipeline feeds known ciphertexts,
// a queue of issued blocks checks every popped entry, plus table and corner sequences.
`timescale 1ns/1ps
module tb_aes_ct_collect;

  localparam int unsigned LAT   = 11;
  localparam int unsigned DEPTH = 16;
  // sel 0: key 000102..0f / pt 00112233..ff ; sel 1: key 0f1571c9.. / pt 01234567..10
  localparam logic [127:0] CT_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_B = 128'hff0b844a0853bf7c6934ab4364148fb9;

  typedef struct packed {
    logic [3:0]   tag;
    logic [127:0] ct;
  } exp_t;

  typedef struct {
    logic         sel;
    logic [3:0]   tag;
    logic [127:0] exp_ct;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] cryptokey;
  logic [127:0] ct_data;
  logic         ct_valid;
  logic         ct_ready = 1'b0;
  logic         ovf_err;
  logic [3:0]   in_tag = 4'd0;
`ifdef AES_COLLECT_TAG_EN
  logic [3:0]   ct_tag;
`endif

  logic         cur_sel = 1'b0;
  logic [127:0] cur_exp = CT_A;
  logic         issue_pend = 1'b0;
  int           checks = 0;
  int           failures = 0;
  int           issues = 0;
  exp_t         exp_q[$];
  exp_t         sb_e;
  logic [127:0] pipe [LAT];
  vec_t         vecs [12];

  always #5 clk = ~clk;

  aes_ct_collect #(
    .LAT   (LAT),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cryptokey (cryptokey),
`ifdef AES_COLLECT_TAG_EN
    .in_tag    (in_tag),
    .ct_tag    (ct_tag),
`endif
    .ct_data   (ct_data),
    .ct_valid  (ct_valid),
    .ct_ready  (ct_ready),
    .ovf_err   (ovf_err)
  );

  function automatic logic [127:0] aes_stub(input logic sel);
    return sel ? CT_B : CT_A;
  endfunction

  task automatic chk1(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0b want=%0b", name, got, want);
    end
  endtask

  task automatic chkn(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic chk128(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stand-in aes_top: issued blocks emerge LAT cycles later, other slots carry garbage.
  assign cryptokey = pipe[LAT-1];

  always @(posedge clk) begin
    for (int i = int'(LAT) - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= issue_pend ? aes_stub(cur_sel) : {4{$urandom()}};
  end

  // Handshakes are sampled mid-cycle, where inputs and outputs are stable.
  always @(negedge clk) begin
    issue_pend = rst_n && in_valid && in_ready;
    if (issue_pend) begin
      issues++;
      exp_q.push_back('{tag: in_tag, ct: cur_exp});
    end
    if (rst_n && ct_valid && ct_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected got ct_data=%h want no output", ct_data);
      end else begin
        sb_e = exp_q.pop_front();
        chk128("sb_ct", ct_data, sb_e.ct);
`ifdef AES_COLLECT_TAG_EN
        chk128("sb_tag", 128'(ct_tag), 128'(sb_e.tag));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           n;
    int           cnt;
    int           i0;
    logic         found;
    logic [127:0] head;

    vecs = '{'{1'b1, 4'd1,  CT_B}, '{1'b0, 4'd2,  CT_A},
             '{1'b1, 4'd3,  CT_B}, '{1'b0, 4'd4,  CT_A},
             '{1'b1, 4'd5,  CT_B}, '{1'b0, 4'd6,  CT_A},
             '{1'b1, 4'd7,  CT_B}, '{1'b0, 4'd8,  CT_A},
             '{1'b1, 4'd9,  CT_B}, '{1'b0, 4'd10, CT_A},
             '{1'b1, 4'd11, CT_B}, '{1'b0, 4'd12, CT_A}};

    // Reset values, then in_ready on the first edge after release.
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_ct_valid", ct_valid, 1'b0);
    chk128("rst_ct_data", ct_data, 128'd0);
    chk1("rst_ovf_err", ovf_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk1("rel_in_ready_before_edge", in_ready, 1'b0);
    tick();
    chk1("rel_in_ready_first_edge", in_ready, 1'b1);

    // Single block: latency and held head.
    in_valid = 1'b1; cur_sel = 1'b0; cur_exp = CT_A; in_tag = 4'd0;
    tick();
    in_valid = 1'b0;
    n = 0;
    for (int k = 1; k <= int'(LAT) + 8; k++) begin
      tick();
      if (ct_valid) begin
        n = k;
        break;
      end
    end
    chkn("single_latency", n, int'(LAT));
    chk128("single_ct_data", ct_data, CT_A);
    head = ct_data;
    repeat (3) tick();
    chk128("single_hold_data", ct_data, head);
    chk1("single_hold_valid", ct_valid, 1'b1);
    ct_ready = 1'b1;
    tick();
    ct_ready = 1'b0;
    chk1("single_popped", ct_valid, 1'b0);

    // Back-to-back alternating blocks from the table, consumer always ready.
    ct_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      cur_sel  = vecs[i].sel;
      cur_exp  = vecs[i].exp_ct;
      in_tag   = vecs[i].tag;
      chk1("b2b_in_ready", in_ready, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (ct_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk1("b2b_start", found, 1'b1);
    for (int j = 0; j < 12; j++) begin
      chk1("b2b_no_gap", ct_valid, 1'b1);
      chk128("b2b_ct_data", ct_data, vecs[j].exp_ct);
`ifdef AES_COLLECT_TAG_EN
      chk128("b2b_ct_tag", 128'(ct_tag), 128'(vecs[j].tag));
`endif
      tick();
    end
    chk1("b2b_end_empty", ct_valid, 1'b0);

    // Stalled consumer: exactly DEPTH issues, then no credit and no overflow.
    ct_ready = 1'b0;
    i0 = issues;
    in_valid = 1'b1;
    head = '0;
    for (int k = 0; k < int'(LAT + DEPTH) + 10; k++) begin
      cur_sel = k[0];
      cur_exp = k[0] ? CT_B : CT_A;
      if (k == int'(LAT) + 4) head = ct_data;
      tick();
    end
    chkn("full_issue_count", issues - i0, int'(DEPTH));
    chk1("full_in_ready", in_ready, 1'b0);
    chk1("full_ovf_err", ovf_err, 1'b0);
    chk1("full_ct_valid", ct_valid, 1'b1);
    chk128("full_head", ct_data, CT_A);
    chk128("full_head_stable", ct_data, head);

    // One pop from full: credit one cycle later for exactly one cycle, one new issue.
    i0 = issues;
    ct_ready = 1'b1;
    chk1("pulse_no_comb_path", in_ready, 1'b0);
    tick();
    ct_ready = 1'b0;
    chk1("pulse_credit", in_ready, 1'b1);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (in_ready) cnt++;
    end
    chkn("pulse_extra_ready", cnt, 0);
    chkn("pulse_issue_count", issues - i0, 1);

    // Drain everything, then nothing must remain expected.
    in_valid = 1'b0;
    ct_ready = 1'b1;
    for (int k = 0; k < 80; k++) begin
      if (exp_q.size() == 0 && !ct_valid) break;
      tick();
    end
    chkn("drain_left", exp_q.size(), 0);
    chk1("drain_ovf_err", ovf_err, 1'b0);

    // Mid-operation reset with 2 buffered and 3 in flight.
    ct_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; cur_sel = k[0]; cur_exp = k[0] ? CT_B : CT_A;
      tick();
    end
    in_valid = 1'b0;
    repeat (LAT) tick();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; cur_sel = k[0]; cur_exp = k[0] ? CT_B : CT_A;
      tick();
    end
    in_valid = 1'b0;
    chk1("prerst_ct_valid", ct_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("midrst_ct_valid", ct_valid, 1'b0);
    chk1("midrst_in_ready", in_ready, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ct_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < int'(LAT) + 10; k++) begin
      tick();
      if (ct_valid) cnt++;
    end
    chkn("postrst_outputs", cnt, 0);
    chk128("postrst_ct_data", ct_data, 128'd0);
    chk1("postrst_ovf_err", ovf_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
